// File: rtl/p_flag_sequencer_if.sv
// Operation request and stack-memory handshake bundle for the P-register update sequencer.
interface p_flag_sequencer_if;
  logic       op_valid;
  logic [2:0] op_code;
  logic [7:0] op_imm;
  logic       op_ready;
  logic       done;
  logic       mem_req;
  logic       mem_we;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       mem_ack;

  // Environment side: issues ops and answers stack accesses.
  modport master (
    output op_valid, op_code, op_imm, mem_rdata, mem_ack,
    input  op_ready, done, mem_req, mem_we, mem_wdata
  );

  // Sequencer side.
  modport slave (
    input  op_valid, op_code, op_imm, mem_rdata, mem_ack,
    output op_ready, done, mem_req, mem_we, mem_wdata
  );
endinterface

// File: rtl/p_flag_sequencer.sv
// Writer side of the CPU status-register update path: sequences REP/SEP/PHP/PLP and
// interrupt entry, drives the P write mask/data, and runs the stack byte transfer.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | ready for a new op (op_ready=1)
// S_PUSH  | pushing lat to the stack; sp_dec on the ack cycle
// S_SPINC | pre-increment SP ahead of a pull
// S_PULL  | pulling a byte from the stack into lat
// S_APPLY | one-cycle write into P (mask/data by captured op)
// S_DONE  | one-cycle completion pulse
module p_flag_sequencer (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cpu_en,
  input  logic [7:0]                p_in,
  input  logic                      e_in,
  output logic [7:0]                p_wdata,
  output logic [7:0]                p_write,
  output logic                      sp_dec,
  output logic                      sp_inc,
  p_flag_sequencer_if.slave         bus
);

  localparam logic [2:0] OP_REP = 3'd0;
  localparam logic [2:0] OP_SEP = 3'd1;
  localparam logic [2:0] OP_PHP = 3'd2;
  localparam logic [2:0] OP_PLP = 3'd3;
  localparam logic [2:0] OP_INT = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE, S_PUSH, S_SPINC, S_PULL, S_APPLY, S_DONE
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] lat, lat_nxt;
  logic [2:0] op_q;
  logic [7:0] imm_q;
  logic       e_q;
  logic [7:0] push_byte;
  logic       accept;

  assign accept = (state == S_IDLE) && bus.op_valid;

  // Byte pushed for PHP/INT; in emulation bit 5 reads as 1 and bit 4 carries the B flag.
  always_comb begin
    push_byte = p_in;
    if (e_in) begin
      if (bus.op_code == OP_INT) push_byte = {p_in[7:6], 1'b1, bus.op_imm[0], p_in[3:0]};
      else                       push_byte = {p_in[7:6], 2'b11, p_in[3:0]};
    end
  end

  // State, latched byte and captured op; everything holds while cpu_en is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      lat   <= 8'h00;
      op_q  <= 3'd0;
      imm_q <= 8'h00;
      e_q   <= 1'b0;
    end else if (cpu_en) begin
      state <= state_nxt;
      lat   <= lat_nxt;
      if (accept) begin
        op_q  <= bus.op_code;
        imm_q <= bus.op_imm;
        e_q   <= e_in;
      end
    end
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_nxt     = state;
    lat_nxt       = lat;
    bus.op_ready  = 1'b0;
    bus.done      = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = 8'h00;
    p_write       = 8'h00;
    p_wdata       = 8'h00;
    sp_inc        = 1'b0;
    sp_dec        = 1'b0;
    case (state)
      S_IDLE: begin
        bus.op_ready = 1'b1;
        if (bus.op_valid) begin
          case (bus.op_code)
            OP_REP, OP_SEP: state_nxt = S_APPLY;
            OP_PHP, OP_INT: begin
              state_nxt = S_PUSH;
              lat_nxt   = push_byte;
            end
            OP_PLP:         state_nxt = S_SPINC;
            default:        state_nxt = S_DONE;
          endcase
        end
      end
      S_PUSH: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_wdata = lat;
        if (bus.mem_ack) begin
          // Gated so a dead-cycle ack never looks like an SP update.
          sp_dec    = cpu_en;
          state_nxt = (op_q == OP_INT) ? S_APPLY : S_DONE;
        end
      end
      S_SPINC: begin
        sp_inc    = 1'b1;
        state_nxt = S_PULL;
      end
      S_PULL: begin
        bus.mem_req = 1'b1;
        if (bus.mem_ack) begin
          lat_nxt   = bus.mem_rdata;
          state_nxt = S_APPLY;
        end
      end
      S_APPLY: begin
        case (op_q)
          OP_REP: begin p_write = imm_q; p_wdata = 8'h00; end
          OP_SEP: begin p_write = imm_q; p_wdata = 8'hFF; end
          OP_PLP: begin p_write = 8'hFF; p_wdata = lat;   end
          OP_INT: begin p_write = 8'h0C; p_wdata = 8'h04; end
          default: ;
        endcase
        // In emulation M/X/B are not real register bits for these ops.
        if (e_q && (op_q != OP_INT)) p_write[5:4] = 2'b00;
        state_nxt = S_DONE;
      end
      S_DONE: begin
        bus.done  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_p_flag_sequencer.sv
// Directed bench for p_flag_sequencer: a REP/SEP vector table plus hand sequences
// for the stack ops, cpu_en stalls, reserved codes and mid-op reset.
module tb_p_flag_sequencer;
  logic       clk = 1'b0;
  logic       reset;
  logic       cpu_en;
  logic [7:0] p_in;
  logic       e_in;
  logic [7:0] p_wdata, p_write;
  logic       sp_dec, sp_inc;
  int total = 0;
  int bad   = 0;

  p_flag_sequencer_if bus ();

  p_flag_sequencer dut (
    .clk(clk), .reset(reset), .cpu_en(cpu_en), .p_in(p_in), .e_in(e_in),
    .p_wdata(p_wdata), .p_write(p_write), .sp_dec(sp_dec), .sp_inc(sp_inc),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [7:0] imm;
    logic       e;
    logic [7:0] pin;
    logic [7:0] exp_write;
    logic [7:0] exp_wdata;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  // Advance one clock; inputs are changed and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [7:0] imm, input logic e, input logic [7:0] pin);
    bus.op_valid = 1'b1;
    bus.op_code  = op;
    bus.op_imm   = imm;
    e_in         = e;
    p_in         = pin;
    #1;
    chk("op_ready_idle", {7'd0, bus.op_ready}, 8'h01);
    tick();
    bus.op_valid = 1'b0;
  endtask

  initial begin
    vecs[0] = '{3'd0, 8'h30, 1'b0, 8'hFF, 8'h30, 8'h00};
    vecs[1] = '{3'd1, 8'h31, 1'b1, 8'h00, 8'h01, 8'hFF};
    vecs[2] = '{3'd0, 8'hFF, 1'b1, 8'h34, 8'hCF, 8'h00};
    vecs[3] = '{3'd1, 8'h0C, 1'b0, 8'h00, 8'h0C, 8'hFF};
    vecs[4] = '{3'd0, 8'h00, 1'b0, 8'hAA, 8'h00, 8'h00};
    vecs[5] = '{3'd1, 8'h30, 1'b1, 8'h00, 8'h00, 8'hFF};

    reset = 1'b1; cpu_en = 1'b1; p_in = 8'h00; e_in = 1'b0;
    bus.op_valid = 1'b0; bus.op_code = 3'd0; bus.op_imm = 8'h00;
    bus.mem_rdata = 8'h00; bus.mem_ack = 1'b0;
    tick(); tick();
    chk("rst_op_ready", {7'd0, bus.op_ready}, 8'h01);
    chk("rst_done", {7'd0, bus.done}, 8'h00);
    chk("rst_p_write", p_write, 8'h00);
    chk("rst_p_wdata", p_wdata, 8'h00);
    chk("rst_mem", {4'd0, bus.mem_req, bus.mem_we, sp_inc, sp_dec}, 8'h00);
    reset = 1'b0;
    tick();

    // REP/SEP table: APPLY one cycle after accept, DONE the cycle after.
    for (int i = 0; i < 6; i++) begin
      issue(vecs[i].op, vecs[i].imm, vecs[i].e, vecs[i].pin);
      chk("vec_busy", {7'd0, bus.op_ready}, 8'h00);
      chk("vec_p_write", p_write, vecs[i].exp_write);
      chk("vec_p_wdata", p_wdata, vecs[i].exp_wdata);
      chk("vec_no_done", {7'd0, bus.done}, 8'h00);
      tick();
      chk("vec_done", {7'd0, bus.done}, 8'h01);
      chk("vec_done_nowrite", p_write, 8'h00);
      tick();
      chk("vec_back_idle", {7'd0, bus.op_ready}, 8'h01);
    end

    // Captured e rules for the whole op even if e_in drops right after accept.
    issue(3'd0, 8'hFF, 1'b1, 8'h00);
    e_in = 1'b0; #1;
    chk("e_capture", p_write, 8'hCF);
    tick(); tick();

    // Emulation PHP, one wait cycle; stray op_valid while busy must be ignored.
    issue(3'd2, 8'h00, 1'b1, 8'h23);
    bus.op_valid = 1'b1; bus.op_code = 3'd1; bus.op_imm = 8'hFF;
    #1;
    chk("php_req_we", {6'd0, bus.mem_req, bus.mem_we}, 8'h03);
    chk("php_wdata", bus.mem_wdata, 8'h33);
    chk("php_no_sp_dec_wait", {7'd0, sp_dec}, 8'h00);
    tick();
    bus.mem_ack = 1'b1; #1;
    chk("php_sp_dec", {7'd0, sp_dec}, 8'h01);
    chk("php_no_pwrite", p_write, 8'h00);
    tick();
    bus.mem_ack = 1'b0; bus.op_valid = 1'b0; #1;
    chk("php_done", {7'd0, bus.done}, 8'h01);
    chk("php_req_off", {7'd0, bus.mem_req}, 8'h00);
    chk("php_done_nowrite", p_write, 8'h00);
    tick();
    chk("php_idle", {7'd0, bus.op_ready}, 8'h01);

    // Native PLP with cpu_en toggling and three wait cycles on the pull.
    issue(3'd3, 8'h00, 1'b0, 8'h00);
    chk("plp_sp_inc", {6'd0, bus.mem_req, sp_inc}, 8'h01);
    cpu_en = 1'b0; tick();
    chk("plp_frozen_spinc", {6'd0, bus.mem_req, sp_inc}, 8'h01);
    cpu_en = 1'b1; tick();
    chk("plp_pull", {5'd0, bus.mem_req, bus.mem_we, sp_inc}, 8'h04);
    for (int w = 0; w < 3; w++) begin
      cpu_en = w[0]; tick();
      chk("plp_wait", {7'd0, bus.mem_req}, 8'h01);
    end
    cpu_en = 1'b0; bus.mem_ack = 1'b1; bus.mem_rdata = 8'h55; tick();
    chk("plp_ack_gated", {7'd0, bus.mem_req}, 8'h01);
    cpu_en = 1'b1; bus.mem_rdata = 8'hC3; tick();
    bus.mem_ack = 1'b0; bus.mem_rdata = 8'h00; #1;
    chk("plp_p_write", p_write, 8'hFF);
    chk("plp_p_wdata", p_wdata, 8'hC3);
    chk("plp_req_off", {7'd0, bus.mem_req}, 8'h00);
    cpu_en = 1'b0; tick();
    chk("plp_apply_held", p_wdata, 8'hC3);
    cpu_en = 1'b1; tick();
    chk("plp_done", {7'd0, bus.done}, 8'h01);
    chk("plp_done_nowrite", p_write, 8'h00);
    tick();

    // Emulation INT with BRK flag, 0-wait ack: done 3 cycles after accept.
    issue(3'd4, 8'h01, 1'b1, 8'h28);
    bus.mem_ack = 1'b1; #1;
    chk("int_wdata", bus.mem_wdata, 8'h38);
    chk("int_sp_dec", {7'd0, sp_dec}, 8'h01);
    tick();
    bus.mem_ack = 1'b0; #1;
    chk("int_p_write", p_write, 8'h0C);
    chk("int_p_wdata", p_wdata, 8'h04);
    tick();
    chk("int_done", {7'd0, bus.done}, 8'h01);
    tick();

    // Reserved op code: straight to DONE with no writes or stack traffic.
    issue(3'd6, 8'hFF, 1'b0, 8'h00);
    chk("rsv_done", {7'd0, bus.done}, 8'h01);
    chk("rsv_nowrite", p_write, 8'h00);
    chk("rsv_nomem", {7'd0, bus.mem_req}, 8'h00);
    tick();

    // Reset during PULL, then an immediate REP with a stray ack in APPLY.
    issue(3'd3, 8'h00, 1'b0, 8'h00);
    tick();
    chk("rst_pull_req", {7'd0, bus.mem_req}, 8'h01);
    reset = 1'b1; bus.mem_ack = 1'b1; bus.mem_rdata = 8'h99; tick();
    reset = 1'b0; bus.mem_ack = 1'b0; #1;
    chk("rst_mid_req", {7'd0, bus.mem_req}, 8'h00);
    chk("rst_mid_ready", {7'd0, bus.op_ready}, 8'h01);
    chk("rst_mid_pwrite", p_write, 8'h00);
    issue(3'd0, 8'h04, 1'b0, 8'hFF);
    bus.mem_ack = 1'b1; #1;
    chk("rst_rep_write", p_write, 8'h04);
    chk("rst_rep_nodec", {7'd0, sp_dec}, 8'h00);
    tick();
    bus.mem_ack = 1'b0; #1;
    chk("rst_rep_done", {7'd0, bus.done}, 8'h01);
    tick();
    chk("final_idle", {7'd0, bus.op_ready}, 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
